// File: rtl/minmax_window_ctrl.sv
// minmax_window_ctrl: buffers a sample stream in a FIFO and replays it to a
// downstream minMax tracker in gap-free windows of WINDOW beats. On the last
// beat it captures minMax's midrange output and holds it until a consumer
// takes it.
module minmax_window_ctrl #(
  parameter int unsigned MSB        = 8,
  parameter int unsigned WINDOW     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AW         = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [MSB:0] s_data,
  input  logic         flush,
  output logic         mm_clear,
  output logic         mm_enable,
  output logic         mm_reset,
  output logic [MSB:0] mm_in,
  input  logic [MSB:0] mm_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [MSB:0] res_data
);

  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0]   DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [AW:0]   WIN_CNT   = CW'(WINDOW);
  localparam logic [AW-1:0] LAST_BEAT = AW'(WINDOW - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] beat;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          clear_q;
  logic [MSB:0]  mem [FIFO_DEPTH];

  logic push;
  logic pop;

  // Handshake and minMax control decode; flush blocks push, pop and accumulation
  assign s_ready   = (count != DEPTH_CNT) && !flush;
  assign push      = s_valid && s_ready;
  assign pop       = (state == BURST) && !flush;
  assign mm_enable = pop;
  assign mm_clear  = clear_q || flush;
  assign mm_in     = (state == BURST) ? mem[rd_ptr] : '0;
  assign mm_reset  = 1'b0;

  // Sample storage; contents need no reset since count gates every read
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Window sequencer, result capture and result handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      beat      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      clear_q   <= 1'b1;
    end else begin
      clear_q <= 1'b0;
      if (flush) begin
        state     <= IDLE;
        beat      <= '0;
        res_valid <= 1'b0;
      end else begin
        if (res_valid && res_ready) begin
          res_valid <= 1'b0;
        end
        case (state)
          IDLE: begin
            // Start only with a full window queued and an empty result slot
            if ((count >= WIN_CNT) && !res_valid) begin
              state <= BURST;
              beat  <= '0;
            end
          end
          BURST: begin
            if (beat == LAST_BEAT) begin
              res_data  <= mm_out;
              res_valid <= 1'b1;
              beat      <= '0;
              state     <= IDLE;
            end else begin
              beat <= beat + AW'(1);
            end
          end
          default: begin
            state <= IDLE;
            beat  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_minmax_window_ctrl.sv
// Testbench for minmax_window_ctrl with a behavioural minMax tracker downstream.
module tb_minmax_window_ctrl;

  logic       clk;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [8:0] s_data;
  logic       flush;
  logic       mm_clear;
  logic       mm_enable;
  logic       mm_reset;
  logic [8:0] mm_in;
  logic [8:0] mm_out;
  logic       res_valid;
  logic       res_ready;
  logic [8:0] res_data;

  int checks = 0;
  int errors = 0;

  minmax_window_ctrl #(
    .MSB(8), .WINDOW(8), .FIFO_DEPTH(16), .AW(4)
  ) dut (
    .clock    (clk),
    .reset_n  (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .flush    (flush),
    .mm_clear (mm_clear),
    .mm_enable(mm_enable),
    .mm_reset (mm_reset),
    .mm_in    (mm_in),
    .mm_out   (mm_out),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural minMax: out includes the current input while enabled
  logic [8:0] mn, mx, nmn, nmx, last_out;
  logic       have;
  logic [9:0] sum;
  always_comb begin
    nmn = mm_in;
    nmx = mm_in;
    if (have && mn < mm_in) nmn = mn;
    if (have && mx > mm_in) nmx = mx;
    sum = {1'b0, nmn} + {1'b0, nmx};
    mm_out = mm_enable ? sum[9:1] : last_out;
  end
  always_ff @(posedge clk) begin
    if (mm_clear || mm_reset) begin
      have     <= 1'b0;
      last_out <= '0;
    end else if (mm_enable) begin
      mn       <= nmn;
      mx       <= nmx;
      have     <= 1'b1;
      last_out <= mm_out;
    end else begin
      have <= 1'b0;
    end
  end

  typedef struct {
    logic       sv;
    logic [8:0] sd;
    logic       rr;
    logic       fl;
    logic       e_clr;
    logic       e_srdy;
    logic       e_en;
    logic [8:0] e_in;
    logic       e_rv;
    logic [8:0] e_rd;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic sv, input logic [8:0] sd, input logic rr, input logic fl);
    @(negedge clk);
    s_valid   = sv;
    s_data    = sd;
    res_ready = rr;
    flush     = fl;
    #1;
  endtask

  task automatic wait_result(input logic [8:0] exp, input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 9'd0, 1'b0, 1'b0);
      if (res_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, " res_valid seen"}, 32'(got), 32'd1);
    chk({tag, " res_data"}, 32'(res_data), 32'(exp));
  endtask

  task automatic accept(input string tag);
    drive(1'b0, 9'd0, 1'b1, 1'b0);
    chk({tag, " res_valid at accept"}, 32'(res_valid), 32'd1);
  endtask

  task automatic idle_watch(input int n, input logic exp_rv, input string tag);
    int en_seen;
    int rv_bad;
    en_seen = 0;
    rv_bad  = 0;
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 9'd0, 1'b0, 1'b0);
      if (mm_enable !== 1'b0) en_seen++;
      if (res_valid !== exp_rv) rv_bad++;
    end
    chk({tag, " mm_enable cycles"}, 32'(en_seen), 32'd0);
    chk({tag, " res_valid wrong cycles"}, 32'(rv_bad), 32'd0);
  endtask

  task automatic push_n(input int n, input logic [8:0] v, input string tag);
    int not_rdy;
    not_rdy = 0;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, v, 1'b0, 1'b0);
      if (s_ready !== 1'b1) not_rdy++;
    end
    chk({tag, " s_ready low during pushes"}, 32'(not_rdy), 32'd0);
  endtask

  task automatic wait_enable(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 9'd0, 1'b0, 1'b0);
      if (mm_enable === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, " burst started"}, 32'(seen), 32'd1);
  endtask

  // Bound the whole run
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int not_rdy;
    // Test 1 table: 8 pushes, idle evaluation, 8 burst beats, result, release
    for (int i = 0; i < 19; i++) begin
      vecs[i].sv = 1'b0;  vecs[i].sd = '0;      vecs[i].rr = 1'b1; vecs[i].fl = 1'b0;
      vecs[i].e_clr = 1'b0; vecs[i].e_srdy = 1'b1; vecs[i].e_en = 1'b0;
      vecs[i].e_in = '0;  vecs[i].e_rv = 1'b0;  vecs[i].e_rd = '0;
      if (i < 8) begin
        vecs[i].sv = 1'b1;
        vecs[i].sd = 9'(10 * (i + 1));
      end
      if (i >= 9 && i <= 16) begin
        vecs[i].e_en = 1'b1;
        vecs[i].e_in = 9'(10 * (i - 8));
      end
      if (i == 17) begin
        vecs[i].e_rv = 1'b1;
        vecs[i].e_rd = 9'd45;
      end
      if (i == 18) vecs[i].e_rd = 9'd45;
    end

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; flush = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset s_ready", 32'(s_ready), 32'd1);
    chk("reset mm_clear", 32'(mm_clear), 32'd1);
    chk("reset mm_enable", 32'(mm_enable), 32'd0);
    chk("reset mm_in", 32'(mm_in), 32'd0);
    chk("reset mm_reset", 32'(mm_reset), 32'd0);
    chk("reset res_valid", 32'(res_valid), 32'd0);
    chk("reset res_data", 32'(res_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release mm_clear", 32'(mm_clear), 32'd1);

    // Test 1
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].sv, vecs[i].sd, vecs[i].rr, vecs[i].fl);
      chk($sformatf("t1[%0d] mm_clear", i), 32'(mm_clear), 32'(vecs[i].e_clr));
      chk($sformatf("t1[%0d] s_ready", i), 32'(s_ready), 32'(vecs[i].e_srdy));
      chk($sformatf("t1[%0d] mm_enable", i), 32'(mm_enable), 32'(vecs[i].e_en));
      chk($sformatf("t1[%0d] mm_in", i), 32'(mm_in), 32'(vecs[i].e_in));
      chk($sformatf("t1[%0d] res_valid", i), 32'(res_valid), 32'(vecs[i].e_rv));
      chk($sformatf("t1[%0d] res_data", i), 32'(res_data), 32'(vecs[i].e_rd));
    end

    // Test 2: held result blocks the second window
    push_n(8, 9'd511, "t2a");
    push_n(8, 9'd0, "t2b");
    wait_result(9'd511, "t2 first");
    idle_watch(20, 1'b1, "t2 hold");
    chk("t2 held res_data", 32'(res_data), 32'd511);
    accept("t2 first");
    wait_result(9'd0, "t2 second");

    // Test 3: fill to 16 while result is held; 17th sample refused
    not_rdy = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 9'(i + 1), 1'b0, 1'b0);
      if (s_ready !== 1'b1) not_rdy++;
    end
    chk("t3 s_ready low during fill", 32'(not_rdy), 32'd0);
    drive(1'b1, 9'd200, 1'b0, 1'b0);
    chk("t3 s_ready at full", 32'(s_ready), 32'd0);
    accept("t3 release");
    wait_result(9'd4, "t3 window1");
    chk("t3 s_ready after pop", 32'(s_ready), 32'd1);
    accept("t3 window1");
    wait_result(9'd12, "t3 window2");
    accept("t3 window2");
    idle_watch(20, 1'b0, "t3 drained");

    // Test 4: seven samples do not start a window; the eighth does
    push_n(7, 9'd30, "t4");
    idle_watch(10, 1'b0, "t4 seven");
    drive(1'b1, 9'd2, 1'b0, 1'b0);
    chk("t4 push cycle mm_enable", 32'(mm_enable), 32'd0);
    drive(1'b0, 9'd0, 1'b0, 1'b0);
    chk("t4 eval cycle mm_enable", 32'(mm_enable), 32'd0);
    drive(1'b0, 9'd0, 1'b0, 1'b0);
    chk("t4 beat0 mm_enable", 32'(mm_enable), 32'd1);
    chk("t4 beat0 mm_in", 32'(mm_in), 32'd30);
    wait_result(9'd16, "t4");
    accept("t4");

    // Test 5: flush on beat 3 discards the window
    push_n(8, 9'd50, "t5");
    wait_enable("t5");
    drive(1'b0, 9'd0, 1'b0, 1'b0);
    drive(1'b0, 9'd0, 1'b0, 1'b0);
    chk("t5 beat2 mm_in", 32'(mm_in), 32'd50);
    drive(1'b1, 9'd77, 1'b0, 1'b1);
    chk("t5 flush mm_clear", 32'(mm_clear), 32'd1);
    chk("t5 flush mm_enable", 32'(mm_enable), 32'd0);
    chk("t5 flush s_ready", 32'(s_ready), 32'd0);
    drive(1'b0, 9'd0, 1'b0, 1'b0);
    chk("t5 after flush mm_clear", 32'(mm_clear), 32'd0);
    idle_watch(15, 1'b0, "t5 flushed");
    push_n(8, 9'd100, "t5 clean");
    wait_result(9'd100, "t5 clean");
    accept("t5 clean");

    // Test 6: asynchronous reset mid-burst
    push_n(8, 9'd60, "t6");
    wait_enable("t6");
    drive(1'b0, 9'd0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 reset mm_enable", 32'(mm_enable), 32'd0);
    chk("t6 reset mm_in", 32'(mm_in), 32'd0);
    chk("t6 reset mm_clear", 32'(mm_clear), 32'd1);
    chk("t6 reset res_valid", 32'(res_valid), 32'd0);
    chk("t6 reset res_data", 32'(res_data), 32'd0);
    chk("t6 reset s_ready", 32'(s_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6 release mm_clear", 32'(mm_clear), 32'd1);
    drive(1'b0, 9'd0, 1'b0, 1'b0);
    chk("t6 post release mm_clear", 32'(mm_clear), 32'd0);
    idle_watch(12, 1'b0, "t6 empty");
    push_n(8, 9'd7, "t6 clean");
    wait_result(9'd7, "t6 clean");
    accept("t6 clean");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
